// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester shared-ALU arbiter.
package alu_share_arbiter_pkg;

  // Operand bundle and result widths
  localparam int unsigned OP_W     = 97;
  localparam int unsigned DATA_W   = 32;

  // Field offsets inside the operand bundle (LSB positions)
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned ALUCTL_LSB = 16;
  localparam int unsigned ALUCTL_W   = 6;
  localparam int unsigned SHAMT_LSB  = 22;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned RT_LSB     = 27;
  localparam int unsigned RS_LSB     = 59;
  localparam int unsigned OPC_LSB    = 91;
  localparam int unsigned OPC_W      = 6;

  // Operand bundle view, same packing as the flat bus
  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [4:0]  shamt;
    logic [5:0]  alu_control;
    logic [15:0] immediate;
  } alu_op_t;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Requester identifier
  typedef logic req_id_t;
  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Two-way grant decision: a lone requester wins; on a tie either
  // alternate away from the last served one or favour requester 0.
  function automatic req_id_t pick_grant(input bit fair, input req_id_t last,
                                         input logic v0, input logic v1);
    req_id_t id;
    id = REQ0;
    if (v0 && v1) begin
      id = fair ? req_id_t'(~last) : REQ0;
    end else if (v1) begin
      id = REQ1;
    end
    return id;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_grant.sv
// Two-way grant selection with optional round-robin pointer.
module alu_rr_grant
  import alu_share_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_valid0,
  input  logic    i_valid1,
  input  logic    i_accept,
  output req_id_t o_grant_id_c,
  output logic    o_grant_any_c
);

  req_id_t r_last;
  req_id_t w_grant_id;

  // Combinational grant from current requests and last-served pointer
  always_comb begin
    w_grant_id = pick_grant(FAIR, r_last, i_valid0, i_valid1);
  end

  // Pointer moves only when the granted request is actually accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ1;
    end else if (i_accept) begin
      r_last <= w_grant_id;
    end
  end

  assign o_grant_id_c  = w_grant_id;
  assign o_grant_any_c = i_valid0 | i_valid1;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, one op in flight.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_branch,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_branch,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  req_id_t             r_owner;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_branch;

  req_id_t             w_grant_id;
  logic                w_grant_any;
  logic                w_accept;
  logic                w_owner_ready;
  logic                w_rsp_done;
  logic [OP_W-1:0]     w_sel_op;

  // Grant logic and last-served pointer
  alu_rr_grant #(
    .FAIR (FAIR)
  ) u_grant (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid0      (req0_valid),
    .i_valid1      (req1_valid),
    .i_accept      (w_accept),
    .o_grant_id_c  (w_grant_id),
    .o_grant_any_c (w_grant_any)
  );

  // Handshake, owner-release and operand selection
  assign w_accept      = (r_state == ST_IDLE) && w_grant_any;
  assign w_owner_ready = (r_owner == REQ1) ? rsp1_ready : rsp0_ready;
  assign w_rsp_done    = (r_state == ST_RESP) && w_owner_ready;
  assign w_sel_op      = (w_grant_id == REQ1) ? req1_op : req0_op;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: accept -> one ALU cycle -> hold response until taken
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
      ST_EXEC:                 w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand bundle and owner load on handshake only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op <= '0;
      r_owner  <= REQ0;
    end else if (w_accept) begin
      r_alu_op <= w_sel_op;
      r_owner  <= w_grant_id;
    end
  end

  // Capture ALU outputs during the execute cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= '0;
      r_rsp_branch <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_result <= alu_result;
      r_rsp_branch <= alu_branch;
    end
  end

  // Ready is gated by reset so it drops the moment reset asserts
  assign req0_ready = rst_n & w_accept & (w_grant_id == REQ0);
  assign req1_ready = rst_n & w_accept & (w_grant_id == REQ1);

  assign rsp0_valid = (r_state == ST_RESP) & (r_owner == REQ0);
  assign rsp1_valid = (r_state == ST_RESP) & (r_owner == REQ1);
  assign rsp_result = r_rsp_result;
  assign rsp_branch = r_rsp_branch;
  assign alu_op     = r_alu_op;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: FAIR=1 and FAIR=0 instances on shared stimulus,
// checked every cycle against a transaction-level model plus literal checks.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [96:0] req0_op, req1_op;
  logic        rsp0_ready, rsp1_ready;

  // FAIR=1 instance signals
  logic        f_rdy0, f_rdy1, f_vld0, f_vld1, f_brn, f_bsy, f_abr;
  logic [96:0] f_aop;
  logic [31:0] f_res, f_ares;
  logic [32:0] f_alu;
  // FAIR=0 instance signals
  logic        x_rdy0, x_rdy1, x_vld0, x_vld1, x_brn, x_bsy, x_abr;
  logic [96:0] x_aop;
  logic [31:0] x_res, x_ares;
  logic [32:0] x_alu;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  // Reference ALU: result by ALU_control, branch = signed rs > rt
  function automatic logic [32:0] alu_f(input logic [96:0] op);
    logic [31:0] rs, rt, r;
    logic [4:0]  sh;
    logic [5:0]  ctl;
    logic [15:0] imm;
    rs = op[90:59]; rt = op[58:27]; sh = op[26:22]; ctl = op[21:16]; imm = op[15:0];
    case (ctl)
      6'd0:    r = rs + rt;
      6'd1:    r = rs - rt;
      6'd2:    r = rs & rt;
      6'd3:    r = rs | rt;
      6'd4:    r = rt << sh;
      6'd5:    r = rs + {{16{imm[15]}}, imm};
      default: r = rs ^ rt;
    endcase
    return {($signed(rs) > $signed(rt)), r};
  endfunction

  function automatic logic [96:0] mk(input logic [5:0] opc, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [4:0] sh,
                                     input logic [5:0] ctl, input logic [15:0] imm);
    return {opc, rs, rt, sh, ctl, imm};
  endfunction

  function automatic logic pick(input bit fair, input logic last, input logic v0, input logic v1);
    if (v0 && v1) return fair ? !last : 1'b0;
    return v1 && !v0;
  endfunction

  assign f_alu = alu_f(f_aop);
  assign f_ares = f_alu[31:0];
  assign f_abr  = f_alu[32];
  assign x_alu = alu_f(x_aop);
  assign x_ares = x_alu[31:0];
  assign x_abr  = x_alu[32];

  alu_share_arbiter #(.FAIR(1'b1)) u_fair (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_rdy0), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(f_rdy1), .req1_op(req1_op),
    .alu_op(f_aop), .alu_result(f_ares), .alu_branch(f_abr),
    .rsp0_valid(f_vld0), .rsp0_ready(rsp0_ready),
    .rsp1_valid(f_vld1), .rsp1_ready(rsp1_ready),
    .rsp_result(f_res), .rsp_branch(f_brn), .busy(f_bsy)
  );

  alu_share_arbiter #(.FAIR(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(x_rdy0), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(x_rdy1), .req1_op(req1_op),
    .alu_op(x_aop), .alu_result(x_ares), .alu_branch(x_abr),
    .rsp0_valid(x_vld0), .rsp0_ready(rsp0_ready),
    .rsp1_valid(x_vld1), .rsp1_ready(rsp1_ready),
    .rsp_result(x_res), .rsp_branch(x_brn), .busy(x_bsy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [96:0] act, input logic [96:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: k=0 round-robin, k=1 fixed priority.
  // phase: 0 no op outstanding, 1 op accepted last edge, 2 response held.
  int          m_phase [2];
  logic        m_owner [2];
  logic        m_last  [2];
  logic [96:0] m_op    [2];
  logic [31:0] m_res   [2];
  logic        m_br    [2];
  int          mlog_f[$], mlog_x[$], dlog_f[$], dlog_x[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0; m_owner[k] = 1'b0; m_last[k] = 1'b1;
        m_op[k] = '0; m_res[k] = '0; m_br[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic g;
        logic [32:0] a;
        if (m_phase[k] == 0) begin
          if (req0_valid || req1_valid) begin
            g = pick(k == 0, m_last[k], req0_valid, req1_valid);
            m_op[k] = g ? req1_op : req0_op;
            m_owner[k] = g;
            m_last[k] = g;
            m_phase[k] = 1;
            if (k == 0) mlog_f.push_back(int'(g)); else mlog_x.push_back(int'(g));
          end
        end else if (m_phase[k] == 1) begin
          a = alu_f(m_op[k]);
          m_res[k] = a[31:0];
          m_br[k] = a[32];
          m_phase[k] = 2;
        end else if ((m_owner[k] ? rsp1_ready : rsp0_ready)) begin
          m_phase[k] = 0;
        end
      end
    end
  end

  task automatic check_dut(input int k, input logic r0, input logic r1, input logic v0,
                           input logic v1, input logic [96:0] op, input logic [31:0] rr,
                           input logic rb, input logic bz);
    logic g, any, idle;
    g = pick(k == 0, m_last[k], req0_valid, req1_valid);
    any = req0_valid || req1_valid;
    idle = (m_phase[k] == 0);
    check($sformatf("dut%0d req0_ready", k), 97'(r0), 97'(rst_n && idle && any && !g));
    check($sformatf("dut%0d req1_ready", k), 97'(r1), 97'(rst_n && idle && any && g));
    check($sformatf("dut%0d rsp0_valid", k), 97'(v0), 97'(m_phase[k] == 2 && !m_owner[k]));
    check($sformatf("dut%0d rsp1_valid", k), 97'(v1), 97'(m_phase[k] == 2 && m_owner[k]));
    check($sformatf("dut%0d alu_op", k), op, m_op[k]);
    check($sformatf("dut%0d rsp_result", k), 97'(rr), 97'(m_res[k]));
    check($sformatf("dut%0d rsp_branch", k), 97'(rb), 97'(m_br[k]));
    check($sformatf("dut%0d busy", k), 97'(bz), 97'(!idle));
  endtask

  // Per-cycle comparison and DUT handshake log, sampled mid-cycle
  always @(negedge clk) begin
    if (cmp_on) begin
      check_dut(0, f_rdy0, f_rdy1, f_vld0, f_vld1, f_aop, f_res, f_brn, f_bsy);
      check_dut(1, x_rdy0, x_rdy1, x_vld0, x_vld1, x_aop, x_res, x_brn, x_bsy);
    end
    if (f_rdy0 && req0_valid) dlog_f.push_back(0);
    if (f_rdy1 && req1_valid) dlog_f.push_back(1);
    if (x_rdy0 && req0_valid) dlog_x.push_back(0);
    if (x_rdy1 && req1_valid) dlog_x.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: simulation did not complete");
    finish_run();
  end

  logic [96:0] op_a, op_b0, op_b1, op_c, op_e1, op_e2;
  int exp_f [4];
  int exp_x [4];

  initial begin
    op_a  = mk(6'b010010, 32'd15, 32'd12, 5'd0, 6'd0, 16'd19);
    op_b0 = mk(6'd1, 32'd7, 32'd5, 5'd0, 6'd2, 16'd0);
    op_b1 = mk(6'd2, 32'd3, 32'd4, 5'd2, 6'd4, 16'd0);
    op_c  = mk(6'd3, 32'h0000_00F0, 32'h0000_000F, 5'd0, 6'd3, 16'd0);
    op_e1 = mk(6'd4, 32'd23, 32'd2, 5'd0, 6'd1, 16'd0);
    op_e2 = mk(6'd5, 32'd1, 32'd35, 5'd0, 6'd0, 16'd0);
    exp_f = '{0, 1, 0, 1};
    exp_x = '{0, 0, 0, 0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick(); tick();
    cmp_on = 1'b1;
    #1;
    check("reset busy", 97'(f_bsy), 97'(0));
    check("reset alu_op", f_aop, 97'(0));
    check("reset rsp_result", 97'(f_res), 97'(0));
    rst_n = 1'b1;

    // Single op from requester 0
    tick();
    req0_valid = 1'b1; req0_op = op_a;
    #1;
    check("A fair req0_ready", 97'(f_rdy0), 97'(1));
    check("A fix req0_ready", 97'(x_rdy0), 97'(1));
    tick();
    req0_valid = 1'b0;
    #1;
    check("A alu_op", f_aop, op_a);
    check("A busy", 97'(f_bsy), 97'(1));
    tick();
    #1;
    check("A rsp0_valid", 97'(f_vld0), 97'(1));
    check("A rsp_result", 97'(f_res), 97'(27));
    check("A rsp_branch", 97'(f_brn), 97'(1));
    check("A model result", 97'(m_res[0]), 97'(27));
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    #1;
    check("A idle busy", 97'(f_bsy), 97'(0));
    check("A alu_op held", f_aop, op_a);

    // Continuous tie from a fresh reset
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mlog_f.delete(); mlog_x.delete(); dlog_f.delete(); dlog_x.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = op_b0; req1_op = op_b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (12) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("tie fair count", 97'(dlog_f.size()), 97'(4));
    check("tie fix count", 97'(dlog_x.size()), 97'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tie fair grant%0d", i), 97'(i < dlog_f.size() ? dlog_f[i] : -1), 97'(exp_f[i]));
      check($sformatf("tie fix grant%0d", i), 97'(i < dlog_x.size() ? dlog_x[i] : -1), 97'(exp_x[i]));
      check($sformatf("tie model fair grant%0d", i), 97'(i < mlog_f.size() ? mlog_f[i] : -1), 97'(exp_f[i]));
      check($sformatf("tie model fix grant%0d", i), 97'(i < mlog_x.size() ? mlog_x[i] : -1), 97'(exp_x[i]));
    end

    // Response backpressure on requester 1, non-owner ready ignored
    req1_valid = 1'b1; req1_op = op_c;
    tick();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_op = op_a;
    tick();
    rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d rsp1_valid", i), 97'(f_vld1), 97'(1));
      check($sformatf("bp%0d rsp_result", i), 97'(f_res), 97'(32'hFF));
      check($sformatf("bp%0d req_ready", i), 97'({f_rdy0, f_rdy1}), 97'(0));
      tick();
    end
    rsp1_ready = 1'b1; rsp0_ready = 1'b0; req0_valid = 1'b0;
    tick();
    rsp1_ready = 1'b0;
    #1;
    check("bp idle busy", 97'(f_bsy), 97'(0));

    // Reset during the execute cycle
    tick();
    req0_valid = 1'b1; req0_op = op_b0;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstx busy", 97'(f_bsy), 97'(0));
    check("rstx alu_op", f_aop, 97'(0));
    check("rstx rsp_result", 97'(f_res), 97'(0));
    check("rstx valids", 97'({f_vld0, f_vld1, f_rdy0, f_rdy1}), 97'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rstx%0d rsp0_valid", i), 97'(f_vld0), 97'(0));
      tick();
    end
    req0_valid = 1'b1; req0_op = op_a; rsp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    check("post-reset rsp0_valid", 97'(f_vld0), 97'(1));
    check("post-reset rsp_result", 97'(f_res), 97'(27));
    tick();
    rsp0_ready = 1'b0;

    // Branch flag set and clear
    req1_valid = 1'b1; req1_op = op_e1; rsp1_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    check("br1 rsp1_valid", 97'(f_vld1), 97'(1));
    check("br1 rsp_branch", 97'(f_brn), 97'(1));
    check("br1 rsp_result", 97'(f_res), 97'(21));
    tick();
    rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_op = op_e2; rsp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    check("br0 rsp0_valid", 97'(f_vld0), 97'(1));
    check("br0 rsp_branch", 97'(f_brn), 97'(0));
    check("br0 rsp_result", 97'(f_res), 97'(36));
    tick();
    rsp0_ready = 1'b0;
    repeat (3) tick();
    finish_run();
  end

endmodule
